// File: rtl/buzz_pkg.sv
// Shared types and constants for the quiz buzzer arbiter.
// Round-robin pick helper lives here so it stays next to the width constants.
package buzz_pkg;

   localparam int NUM_PLAYERS = 4;
   localparam int PIDX_W      = 2;
   localparam int CNT_W       = 26;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_GRANTED = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   // First set bit of elig searching upward from ptr, wrapping.
   function automatic logic [PIDX_W-1:0] rr_pick(
      input logic [NUM_PLAYERS-1:0] elig,
      input logic [PIDX_W-1:0]      ptr
   );
      logic [PIDX_W-1:0] idx;
      rr_pick = ptr;
      for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
         idx = ptr + PIDX_W'(k);
         if (elig[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the raw buzzer lines plus a history
// flop that turns each press into a single-cycle rise pulse.
module sync_edge
   import buzz_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PLAYERS-1:0] d,
   output logic [NUM_PLAYERS-1:0] rise
);

   logic [NUM_PLAYERS-1:0] s1_q, s1_d;
   logic [NUM_PLAYERS-1:0] s2_q, s2_d;
   logic [NUM_PLAYERS-1:0] s3_q, s3_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/buzz_arbiter.sv
// Quiz buzzer arbiter: early-buzz lockout, round-robin tie break,
// and a bounded answer window, all driven by CPU arm/ack strobes.
module buzz_arbiter #(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int NUM_PLAYERS    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PLAYERS-1:0] req,
   input  logic                   arm,
   input  logic                   ack,
   output logic                   winner_valid,
   output logic [1:0]             winner,
   output logic                   timed_out,
   output logic                   armed,
   output logic [NUM_PLAYERS-1:0] lock_mask
);

   import buzz_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_PLAYERS-1:0] lock_q, lock_d;
   logic [PIDX_W-1:0]      rr_q, rr_d;
   logic [PIDX_W-1:0]      win_q, win_d;

   logic [NUM_PLAYERS-1:0] rise;
   logic [NUM_PLAYERS-1:0] elig;
   logic [PIDX_W-1:0]      pick;

   sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (req),
      .rise (rise)
   );

   assign elig = rise & ~lock_q;
   assign pick = rr_pick(elig, rr_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      rr_d    = rr_q;
      win_d   = win_q;
      unique case (state_q)
         S_IDLE: begin
            // Rises here, including one coincident with arm, lock out.
            lock_d = lock_q | rise;
            if (arm) begin
               state_d = S_ARMED;
               cnt_d   = '0;
            end
         end
         S_ARMED: begin
            if (ack) begin
               state_d = S_IDLE;
               lock_d  = '0;
               cnt_d   = '0;
            end else if (|elig) begin
               state_d = S_GRANTED;
               win_d   = pick;
               rr_d    = pick + 2'd1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_TIMEOUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (ack) begin
               state_d = S_IDLE;
               lock_d  = '0;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lock_q  <= '0;
         rr_q    <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
      end
   end

   assign armed        = (state_q == S_ARMED);
   assign winner_valid = (state_q == S_GRANTED);
   assign timed_out    = (state_q == S_TIMEOUT);
   assign winner       = win_q;
   assign lock_mask    = lock_q;

endmodule

// File: doc/buzz_arbiter.md
BUZZ_ARBITER -- requirements
Module: buzz_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000000, answer window length in clk cycles (1 s at 50 MHz); legal range 2..2^26-1.
REQ-002 SHALL have parameter NUM_PLAYERS, default 4, fixed at 4 in this revision.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  4  raw player buzzer lines from controller pins, asynchronous to clk, 1 = pressed.
REQ-006 arm  input  1  one-cycle CPU strobe opening a round.
REQ-007 ack  input  1  one-cycle CPU strobe closing or aborting a round.
REQ-008 winner_valid  output  1  round won, winner field meaningful.
REQ-009 winner  output  2  index of winning player.
REQ-010 timed_out  output  1  round closed with no eligible buzz.
REQ-011 armed  output  1  answer window open.
REQ-012 lock_mask  output  4  players disqualified for current round.

Function
REQ-013 SHALL pass each req bit through a 2-flop synchronizer and a third history flop; rise[i] = sync2[i] & ~sync3[i].
REQ-014 SHALL implement states IDLE, ARMED, GRANTED, TIMEOUT; armed=1 only in ARMED, winner_valid=1 only in GRANTED, timed_out=1 only in TIMEOUT.
REQ-015 IDLE: rise[i] sets lock_mask[i] (early-buzz lockout); arm -> ARMED with window counter cleared to 0; ack ignored.
REQ-016 rise[i] in the same cycle as arm SHALL set lock_mask[i] and not count as a buzz.
REQ-017 ARMED: eligible = rise & ~lock_mask; any eligible -> GRANTED with winner latched; counter increments each cycle otherwise.
REQ-018 ARMED: counter reaching TIMEOUT_CYCLES-1 with no eligible buzz -> TIMEOUT; eligible buzz in that same cycle wins (GRANTED).
REQ-019 ARMED: ack -> IDLE (abort) and takes priority over buzz and timeout in the same cycle.
REQ-020 Simultaneous eligible buzzes SHALL be resolved round-robin: search order starts at rr_ptr, ascending mod 4.
REQ-021 rr_ptr SHALL update to (winner+1) mod 4 on each grant only; unchanged on timeout or abort.
REQ-022 GRANTED/TIMEOUT: ack -> IDLE; all buzzes ignored; winner held stable until ack.
REQ-023 Every transition to IDLE SHALL clear lock_mask to 0 and counter to 0; winner retains last value.
REQ-024 arm outside IDLE SHALL be ignored.
REQ-025 Latency: req high first sampled at edge k -> winner_valid high after edge k+2 (ARMED, eligible, no ack).
REQ-026 A held button SHALL produce one rise only; re-buzz requires release and re-press.
REQ-027 Counter SHALL be 26 bits, never wrap in ARMED.

Reset
REQ-028 rst low SHALL immediately force IDLE, winner_valid=0, winner=0, timed_out=0, armed=0, lock_mask=0, rr_ptr=0, counter=0, sync/history flops=0.
REQ-029 Reset mid-round SHALL discard the round; a button held through reset release SHALL register one rise two cycles after release (and lock if in IDLE).

Structure
REQ-030 Shared package buzz_pkg SHALL hold the state enum, NUM_PLAYERS, and player-index width constant.
REQ-031 One sub-module sync_edge (4-bit 2-flop sync plus rise detect) SHALL be instantiated; arbitration and FSM stay in buzz_arbiter.

Verification
REQ-032 arm, then req=4'b0100 5 cycles later -> winner_valid=1, winner=2 after 2 cycles; ack -> IDLE, rr_ptr=3.
REQ-033 From reset, armed, req=4'b1010 same edge -> winner=1; next round same stimulus -> winner=3.
REQ-034 req[0] pressed in IDLE, then arm, req[0] re-pressed, then req[3] -> lock_mask=4'b0001, winner=3.
REQ-035 TIMEOUT_CYCLES=10, arm, no req -> timed_out=1 after 10 cycles in ARMED; ack -> IDLE, all outputs 0 except winner.
REQ-036 armed, ack and eligible rise in same cycle -> IDLE, winner_valid stays 0; rst pulsed in GRANTED -> all outputs 0 asynchronously.
